demux_scan: RTL
===============

// Module: demux_scan
// PURPOSE
//  Registered, parametrised successor of the active-low 3-to-7 channel demux.
//  Drives one of N_OUT active-low enable lines, either from a manual select or by
//  auto-scanning all channels with a programmable dwell and dead-time blanking.
//  Sits between the control logic and the multiplexed display/matrix column drivers.
//  Outputs are glitch-free (all registered), and at most one line is active at a time.
// PARAMETERS
//  N_OUT  7     number of output channels (2..2**SEL_W)
//  SEL_W  3     select / channel index width (>= clog2(N_OUT))
//  DWELL  1000  clk cycles each channel is driven in scan mode (>= 1)
//  BLANK  1     all-inactive dead cycles between channel changes (>= 0; 0 = none)
// PORTS
//  clk          in   1       system clock, rising edge
//  reset        in   1       synchronous, active-high reset
//  En           in   1       enable; 0 forces all outputs inactive
//  mode         in   1       0 = manual (use sel), 1 = auto-scan
//  sel          in   SEL_W   manual channel select
//  e            out  N_OUT   channel enables, active LOW, one-hot-low or all-high
//  ch           out  SEL_W   index of channel currently driven (or last driven)
//  frame_start  out  1       1-cycle pulse on first DRIVE cycle of ch 0 in scan mode
// BEHAVIOUR
//  Reset (sampled at clk edge, with priority over everything else): e = all 1s, ch = 0,
//   frame_start = 0, dwell/blank counters = 0, state = IDLE. A mid-operation reset
//   takes effect on the next edge regardless of state.
//  States: IDLE (all inactive), DRIVE (e[ch]=0, others 1), BLANK (all inactive).
//  IDLE: when En=1, go to DRIVE next cycle; scan: ch=0 and frame_start=1; manual: ch=sel.
//  En=0 in any state: next cycle e = all 1s, state = IDLE, counters cleared, ch held.
//  Manual (mode=0), latency 1 cycle from sel to e:
//   - DRIVE while sel==ch: hold; dwell counter unused.
//   - sel!=ch: BLANK for BLANK cycles, then DRIVE with the sel sampled in the last
//     BLANK cycle; with BLANK=0, switch directly on the next cycle.
//   - sel >= N_OUT: no line is driven (e = all 1s), ch = sel, and the FSM stays
//     in DRIVE; an invalid index never produces an active output.
//  Scan (mode=1): DRIVE ch for exactly DWELL cycles, then BLANK cycles, then
//   ch+1; after N_OUT-1, wrap to 0 and pulse frame_start. Period = N_OUT*(DWELL+BLANK).
//  Mode change while En=1: go to BLANK (or directly when BLANK=0); next DRIVE uses
//   the new mode; entering scan restarts at ch 0 with frame_start.
//  The dwell counter is sized clog2(DWELL+1) and the blank counter clog2(BLANK+1);
//   no overflow is possible.
//  Invariant: at most one bit of e is 0 in any cycle.
// TESTING  (N_OUT=7, SEL_W=3, DWELL=3, BLANK=1)
//  1 reset held 2 cycles with En=1, mode=1 -> e=7'b1111111, ch=0, frame_start=0.
//  2 mode=0, En=1, sel=3 -> next cycle e=7'b1110111; sel->5 -> 1 cycle 7'b1111111,
//    then 7'b1011111, ch=5.
//  3 mode=0, sel=7 -> e=7'b1111111 held, ch=7; sel->0 -> blank 1 cycle, e=7'b1111110.
//  4 mode=1 from IDLE -> e[0]=0 for 3 cycles (frame_start on the 1st), 1 cycle blank,
//    e[1]=0 for 3 cycles ... after e[6] and blank, e[0] again; frame_start every 28 cycles.
//  5 scan, drop En during 2nd cycle of e[4] -> next cycle all 1s, ch=4; re-raise En
//    -> restart at e[0] with frame_start=1.
//  6 reset asserted mid-DRIVE of ch 2, and separately mode 1->0 mid-scan with sel=6
//    -> reset: all 1s/ch=0 next edge; mode switch: 1 blank cycle, then e=7'b0111111.
//  All tests: assertion that $countones(~e) <= 1 in every cycle.

Source files
------------

// File: rtl/demux_scan_if.sv
// rtl/demux_scan_if.sv - control/enable bundle between channel controller and column drivers
interface demux_scan_if #(
    parameter int N_OUT = 7,
    parameter int SEL_W = 3
);
    logic             En;
    logic             mode;
    logic [SEL_W-1:0] sel;
    logic [N_OUT-1:0] e;
    logic [SEL_W-1:0] ch;
    logic             frame_start;

    modport master (
        output En,
        output mode,
        output sel,
        input  e,
        input  ch,
        input  frame_start
    );

    modport slave (
        input  En,
        input  mode,
        input  sel,
        output e,
        output ch,
        output frame_start
    );
endinterface

// File: rtl/demux_scan.sv
// rtl/demux_scan.sv - registered active-low channel demux with manual select and auto-scan
module demux_scan #(
    parameter int N_OUT = 7,
    parameter int SEL_W = 3,
    parameter int DWELL = 1000,
    parameter int BLANK = 1
) (
    input  logic       clk,
    input  logic       reset,
    demux_scan_if.slave bus
);
    localparam int DW = (DWELL < 2) ? 1 : $clog2(DWELL + 1);
    localparam int BW = (BLANK < 1) ? 1 : $clog2(BLANK + 1);
    localparam logic [DW-1:0]    DWELL_LAST = DW'(DWELL - 1);
    localparam logic [BW-1:0]    BLANK_LAST = BW'((BLANK > 0) ? BLANK - 1 : 0);
    localparam logic [SEL_W-1:0] CH_LAST    = SEL_W'(N_OUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_BLANK = 2'd2
    } state_t;

    state_t           r_state;
    logic [N_OUT-1:0] r_e;
    logic [SEL_W-1:0] r_ch;
    logic             r_fs;
    logic [DW-1:0]    r_dwell;
    logic [BW-1:0]    r_blank;
    logic             r_mode;     // mode of the DRIVE phase currently/last active
    logic             r_restart;  // blanking caused by a mode change: next scan starts at ch 0

    logic             w_wrap;
    logic [SEL_W-1:0] w_ch_next;
    logic [SEL_W-1:0] w_start_ch;

    // Enable mask for one channel; an index outside the channel range drives nothing.
    function automatic logic [N_OUT-1:0] f_mask(input logic [SEL_W-1:0] idx);
        logic [N_OUT-1:0] m;
        m = '1;
        for (int k = 0; k < N_OUT; k++) begin
            if (idx == SEL_W'(k)) begin
                m[k] = 1'b0;
            end
        end
        return m;
    endfunction

    assign w_wrap     = (r_ch == CH_LAST);
    assign w_ch_next  = w_wrap ? '0 : r_ch + SEL_W'(1);
    assign w_start_ch = bus.mode ? '0 : bus.sel;

    assign bus.e           = r_e;
    assign bus.ch          = r_ch;
    assign bus.frame_start = r_fs;

    // Channel sequencing FSM; every output comes straight from a register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_e       <= '1;
            r_ch      <= '0;
            r_fs      <= 1'b0;
            r_dwell   <= '0;
            r_blank   <= '0;
            r_mode    <= 1'b0;
            r_restart <= 1'b0;
        end else begin
            r_fs <= 1'b0;
            if (!bus.En) begin
                r_state   <= S_IDLE;
                r_e       <= '1;
                r_dwell   <= '0;
                r_blank   <= '0;
                r_restart <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_DRIVE;
                        r_mode  <= bus.mode;
                        r_dwell <= '0;
                        r_ch    <= w_start_ch;
                        r_e     <= f_mask(w_start_ch);
                        r_fs    <= bus.mode;
                    end

                    S_DRIVE: begin
                        if (bus.mode != r_mode) begin
                            // Mode switch: blank out, then restart in the new mode.
                            r_dwell <= '0;
                            if (BLANK == 0) begin
                                r_mode <= bus.mode;
                                r_ch   <= w_start_ch;
                                r_e    <= f_mask(w_start_ch);
                                r_fs   <= bus.mode;
                            end else begin
                                r_state   <= S_BLANK;
                                r_e       <= '1;
                                r_blank   <= '0;
                                r_restart <= 1'b1;
                            end
                        end else if (!r_mode) begin
                            // Manual: hold while sel matches, otherwise move to the new channel.
                            if (bus.sel != r_ch) begin
                                if (BLANK == 0) begin
                                    r_ch <= bus.sel;
                                    r_e  <= f_mask(bus.sel);
                                end else begin
                                    r_state   <= S_BLANK;
                                    r_e       <= '1;
                                    r_blank   <= '0;
                                    r_restart <= 1'b0;
                                end
                            end
                        end else begin
                            // Scan: count out the dwell, then advance.
                            if (r_dwell == DWELL_LAST) begin
                                r_dwell <= '0;
                                if (BLANK == 0) begin
                                    r_ch <= w_ch_next;
                                    r_e  <= f_mask(w_ch_next);
                                    r_fs <= w_wrap;
                                end else begin
                                    r_state   <= S_BLANK;
                                    r_e       <= '1;
                                    r_blank   <= '0;
                                    r_restart <= 1'b0;
                                end
                            end else begin
                                r_dwell <= r_dwell + DW'(1);
                            end
                        end
                    end

                    S_BLANK: begin
                        if (r_blank == BLANK_LAST) begin
                            r_state   <= S_DRIVE;
                            r_mode    <= bus.mode;
                            r_dwell   <= '0;
                            r_blank   <= '0;
                            r_restart <= 1'b0;
                            if (!bus.mode) begin
                                r_ch <= bus.sel;
                                r_e  <= f_mask(bus.sel);
                            end else if (r_restart || !r_mode) begin
                                r_ch <= '0;
                                r_e  <= f_mask('0);
                                r_fs <= 1'b1;
                            end else begin
                                r_ch <= w_ch_next;
                                r_e  <= f_mask(w_ch_next);
                                r_fs <= w_wrap;
                            end
                        end else begin
                            r_blank <= r_blank + BW'(1);
                        end
                    end

                    default: begin
                        r_state <= S_IDLE;
                        r_e     <= '1;
                    end
                endcase
            end
        end
    end
endmodule
